// File: rtl/cr_xp10_decomp_fe_tlv_split.sv
// cr_xp10_decomp_fe_tlv_split
//
// Front-end TLV splitter, the inverse of the back-end merge stage. One show-ahead
// TLV stream comes in and is separated into four outputs:
//   hdr : the sot word of a DATA/DATA_UNK/LZ77 TLV (user header), ready/valid
//   dp  : LZ data beats with byte strobes and a data_type tag, ready/valid
//   ftr : footer words, words 12/13 patched with byte count / error, write+afull
//   pt  : every other TLV, passed through unchanged, write+afull
// Frame data bytes are counted into frm_bcnt (saturating) and compared against
// sw_OLIMIT; an overrun is reported in footer word 13.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_empty, in_tlv, in_rd        show-ahead input FIFO (in_tlv valid while !in_empty)
//   hdr_valid, hdr_tlv, hdr_ready  header output stage
//   dp_valid, dp_data, dp_bytes_valid, dp_data_type, dp_ready
//                                  data beat stage; type 00 mid, 10 last, 11 empty-frame end
//   ftr_wr, ftr_tlv, ftr_afull     footer output
//   pt_wr, pt_tlv, pt_afull        pass-through output
//   sw_OLIMIT, sw_OLIMIT_ERR_CODE  output byte limit and the error code reported on overrun
//   cceip_cfg                      1: footer word 12 is left unpatched
//   frm_bcnt, frm_done             byte count of current/last frame, last-beat accept pulse
//
// TLV word layout (TlvW = 82 bits):
//   [81:74] typen  [73] sot  [72] eot  [71:64] tstrb  [63:0] tdata
// Type codes: DATA 8'h05, DATA_UNK 8'h06, LZ77 8'h07, FTR 8'h09.
// Footer fields: word 12 bytes_out = tdata[OLIMIT_W-1:0], word 13 error_code = tdata[ERR_W-1:0]
// (0 = NO_ERRORS). Footer word 0 is the FTR sot word.
//
// Optional: define CR_XP10_FE_BIP2_CHK_EN to check header tdata[63:62] against a bip2
// (bit 0 = xor of even bits, bit 1 = xor of odd bits of tdata[61:0]). A mismatch makes
// word 13 report sw_OLIMIT_ERR_CODE+1, taking priority over the overrun code.

module cr_xp10_decomp_fe_tlv_split #(
  parameter int unsigned OLIMIT_W = 24,
  parameter int unsigned ERR_W    = 16,
  localparam int unsigned TlvW    = 82
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_empty,
  input  logic [TlvW-1:0]     in_tlv,
  output logic                in_rd,
  output logic                hdr_valid,
  output logic [TlvW-1:0]     hdr_tlv,
  input  logic                hdr_ready,
  output logic                dp_valid,
  output logic [63:0]         dp_data,
  output logic [7:0]          dp_bytes_valid,
  output logic [1:0]          dp_data_type,
  input  logic                dp_ready,
  output logic                ftr_wr,
  output logic [TlvW-1:0]     ftr_tlv,
  input  logic                ftr_afull,
  output logic                pt_wr,
  output logic [TlvW-1:0]     pt_tlv,
  input  logic                pt_afull,
  input  logic [OLIMIT_W-1:0] sw_OLIMIT,
  input  logic [ERR_W-1:0]    sw_OLIMIT_ERR_CODE,
  input  logic                cceip_cfg,
  output logic [OLIMIT_W-1:0] frm_bcnt,
  output logic                frm_done
);

  localparam logic [7:0] TypeData    = 8'h05;
  localparam logic [7:0] TypeDataUnk = 8'h06;
  localparam logic [7:0] TypeLz77    = 8'h07;
  localparam logic [7:0] TypeFtr     = 8'h09;

  typedef enum logic [1:0] {StIdle, StData, StFtr} state_e;

  state_e state_q, state_d;
  logic [5:0] ftr_cnt_q, ftr_cnt_d;
  logic       olimit_err_q;

  // Input word fields.
  logic [7:0]  in_typen;
  logic        in_sot, in_eot;
  logic [7:0]  in_strb;
  logic [63:0] in_data;
  logic        in_is_data;

  assign in_typen   = in_tlv[81:74];
  assign in_sot     = in_tlv[73];
  assign in_eot     = in_tlv[72];
  assign in_strb    = in_tlv[71:64];
  assign in_data    = in_tlv[63:0];
  assign in_is_data = (in_typen == TypeData) || (in_typen == TypeDataUnk) ||
                      (in_typen == TypeLz77);

  // A stage can take a new word if it is empty or its current word leaves this cycle.
  logic hdr_free, dp_free;
  assign hdr_free = !hdr_valid || hdr_ready;
  assign dp_free  = !dp_valid || dp_ready;

  logic        hdr_ld, dp_ld, ftr_ld, pt_ld, bcnt_clr, bcnt_add;
  logic [63:0] dp_ld_data;
  logic [7:0]  dp_ld_strb;
  logic [1:0]  dp_ld_type;

  // Only contiguous low-aligned strobes count; anything else contributes no bytes.
  function automatic logic [3:0] strb_bytes(input logic [7:0] s);
    case (s)
      8'h01:   strb_bytes = 4'd1;
      8'h03:   strb_bytes = 4'd2;
      8'h07:   strb_bytes = 4'd3;
      8'h0f:   strb_bytes = 4'd4;
      8'h1f:   strb_bytes = 4'd5;
      8'h3f:   strb_bytes = 4'd6;
      8'h7f:   strb_bytes = 4'd7;
      8'hff:   strb_bytes = 4'd8;
      default: strb_bytes = 4'd0;
    endcase
  endfunction

  logic [OLIMIT_W:0]   bcnt_sum;
  logic [OLIMIT_W-1:0] bcnt_next;
  assign bcnt_sum  = {1'b0, frm_bcnt} + {{(OLIMIT_W-3){1'b0}}, strb_bytes(in_strb)};
  assign bcnt_next = bcnt_sum[OLIMIT_W] ? '1 : bcnt_sum[OLIMIT_W-1:0];

`ifdef CR_XP10_FE_BIP2_CHK_EN
  logic bip_err_q;

  function automatic logic [1:0] bip2(input logic [61:0] d);
    logic [1:0] b;
    b = 2'b00;
    for (int i = 0; i < 62; i++) begin
      if (i % 2 == 0) b[0] = b[0] ^ d[i];
      else            b[1] = b[1] ^ d[i];
    end
    return b;
  endfunction
`endif

  // Footer patching; ftr_cnt_q is the index of the word at the head of the input.
  logic [TlvW-1:0] ftr_patched;
  always_comb begin
    ftr_patched = in_tlv;
    if (ftr_cnt_q == 6'd12 && !cceip_cfg) begin
      ftr_patched[OLIMIT_W-1:0] = frm_bcnt;
    end
    if (ftr_cnt_q == 6'd13 && in_tlv[ERR_W-1:0] == '0) begin
`ifdef CR_XP10_FE_BIP2_CHK_EN
      if (bip_err_q) ftr_patched[ERR_W-1:0] = sw_OLIMIT_ERR_CODE + ERR_W'(1);
      else
`endif
      if (olimit_err_q) ftr_patched[ERR_W-1:0] = sw_OLIMIT_ERR_CODE;
    end
  end

  // Classification / pop decision and next state.
  always_comb begin
    state_d    = state_q;
    ftr_cnt_d  = ftr_cnt_q;
    in_rd      = 1'b0;
    hdr_ld     = 1'b0;
    dp_ld      = 1'b0;
    ftr_ld     = 1'b0;
    pt_ld      = 1'b0;
    bcnt_clr   = 1'b0;
    bcnt_add   = 1'b0;
    dp_ld_data = '0;
    dp_ld_strb = '0;
    dp_ld_type = 2'b00;
    if (!in_empty) begin
      case (state_q)
        StIdle: begin
          if (in_is_data && in_sot) begin
            // An empty frame also needs the dp stage for its end marker.
            if (hdr_free && (!in_eot || dp_free)) begin
              in_rd    = 1'b1;
              hdr_ld   = 1'b1;
              bcnt_clr = 1'b1;
              if (in_eot) begin
                dp_ld      = 1'b1;
                dp_ld_type = 2'b11;
              end else begin
                state_d = StData;
              end
            end
          end else if (in_typen == TypeFtr && in_sot) begin
            if (!ftr_afull) begin
              in_rd  = 1'b1;
              ftr_ld = 1'b1;
              if (in_eot) begin
                ftr_cnt_d = 6'd0;
              end else begin
                ftr_cnt_d = 6'd1;
                state_d   = StFtr;
              end
            end
          end else if (!pt_afull) begin
            in_rd = 1'b1;
            pt_ld = 1'b1;
          end
        end
        StData: begin
          if (dp_free) begin
            dp_ld = 1'b1;
            if (in_sot) begin
              // Missing eot: close the frame with an empty last beat, leave the sot
              // word in the FIFO so it is handled again from idle.
              dp_ld_type = 2'b10;
              state_d    = StIdle;
            end else begin
              in_rd      = 1'b1;
              bcnt_add   = 1'b1;
              dp_ld_data = in_data;
              dp_ld_strb = in_strb;
              dp_ld_type = in_eot ? 2'b10 : 2'b00;
              if (in_eot) state_d = StIdle;
            end
          end
        end
        StFtr: begin
          if (!ftr_afull) begin
            in_rd  = 1'b1;
            ftr_ld = 1'b1;
            if (in_eot) begin
              ftr_cnt_d = 6'd0;
              state_d   = StIdle;
            end else if (ftr_cnt_q != 6'd63) begin
              ftr_cnt_d = ftr_cnt_q + 6'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pulses on the cycle the last data beat is actually taken, so dp backpressure
  // delays it together with the beat.
  assign frm_done = dp_valid && dp_ready && (dp_data_type == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ftr_cnt_q      <= '0;
      olimit_err_q   <= 1'b0;
      frm_bcnt       <= '0;
      hdr_valid      <= 1'b0;
      hdr_tlv        <= '0;
      dp_valid       <= 1'b0;
      dp_data        <= '0;
      dp_bytes_valid <= '0;
      dp_data_type   <= '0;
      ftr_wr         <= 1'b0;
      ftr_tlv        <= '0;
      pt_wr          <= 1'b0;
      pt_tlv         <= '0;
    end else begin
      state_q   <= state_d;
      ftr_cnt_q <= ftr_cnt_d;

      if (hdr_ld) begin
        hdr_valid <= 1'b1;
        hdr_tlv   <= in_tlv;
      end else if (hdr_ready) begin
        hdr_valid <= 1'b0;
      end

      if (dp_ld) begin
        dp_valid       <= 1'b1;
        dp_data        <= dp_ld_data;
        dp_bytes_valid <= dp_ld_strb;
        dp_data_type   <= dp_ld_type;
      end else if (dp_ready) begin
        dp_valid <= 1'b0;
      end

      ftr_wr <= ftr_ld;
      if (ftr_ld) ftr_tlv <= ftr_patched;
      pt_wr <= pt_ld;
      if (pt_ld) pt_tlv <= in_tlv;

      if (bcnt_clr) begin
        frm_bcnt     <= '0;
        olimit_err_q <= 1'b0;
      end else if (bcnt_add) begin
        frm_bcnt <= bcnt_next;
        if (bcnt_next > sw_OLIMIT) olimit_err_q <= 1'b1;
      end
    end
  end

`ifdef CR_XP10_FE_BIP2_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bip_err_q <= 1'b0;
    end else if (hdr_ld) begin
      bip_err_q <= (in_data[63:62] != bip2(in_data[61:0]));
    end
  end
`endif

endmodule

// File: tb/tb_cr_xp10_decomp_fe_tlv_split.sv
// Self-checking bench for cr_xp10_decomp_fe_tlv_split. A show-ahead FIFO model feeds
// the DUT; expected hdr/dp/ftr/pt words are queued as stimulus is built and compared
// as each output is accepted.

module tb_cr_xp10_decomp_fe_tlv_split;

  localparam int OLIMIT_W = 24;
  localparam int ERR_W    = 16;
  localparam int TLV_W    = 82;

  localparam logic [7:0] TypeData    = 8'h05;
  localparam logic [7:0] TypeDataUnk = 8'h06;
  localparam logic [7:0] TypeLz77    = 8'h07;
  localparam logic [7:0] TypeFtr     = 8'h09;
  localparam logic [ERR_W-1:0] ErrCode = 16'hBEEF;
`ifdef CR_XP10_FE_BIP2_CHK_EN
  localparam bit BipEn = 1'b1;
`else
  localparam bit BipEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_empty = 1'b1;
  logic [TLV_W-1:0]    in_tlv = '0;
  logic                in_rd;
  logic                hdr_valid;
  logic [TLV_W-1:0]    hdr_tlv;
  logic                hdr_ready = 1'b1;
  logic                dp_valid;
  logic [63:0]         dp_data;
  logic [7:0]          dp_bytes_valid;
  logic [1:0]          dp_data_type;
  logic                dp_ready = 1'b1;
  logic                ftr_wr;
  logic [TLV_W-1:0]    ftr_tlv;
  logic                ftr_afull = 1'b0;
  logic                pt_wr;
  logic [TLV_W-1:0]    pt_tlv;
  logic                pt_afull = 1'b0;
  logic [OLIMIT_W-1:0] sw_OLIMIT = 24'd100;
  logic [ERR_W-1:0]    sw_OLIMIT_ERR_CODE = ErrCode;
  logic                cceip_cfg = 1'b0;
  logic [OLIMIT_W-1:0] frm_bcnt;
  logic                frm_done;

  cr_xp10_decomp_fe_tlv_split #(.OLIMIT_W(OLIMIT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_empty(in_empty), .in_tlv(in_tlv), .in_rd(in_rd),
    .hdr_valid(hdr_valid), .hdr_tlv(hdr_tlv), .hdr_ready(hdr_ready),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_bytes_valid(dp_bytes_valid),
    .dp_data_type(dp_data_type), .dp_ready(dp_ready),
    .ftr_wr(ftr_wr), .ftr_tlv(ftr_tlv), .ftr_afull(ftr_afull),
    .pt_wr(pt_wr), .pt_tlv(pt_tlv), .pt_afull(pt_afull),
    .sw_OLIMIT(sw_OLIMIT), .sw_OLIMIT_ERR_CODE(sw_OLIMIT_ERR_CODE), .cceip_cfg(cceip_cfg),
    .frm_bcnt(frm_bcnt), .frm_done(frm_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic [1:0]  t;
  } dp_t;

  logic [TLV_W-1:0] fifo[$];
  logic [TLV_W-1:0] exp_hdr[$];
  logic [TLV_W-1:0] exp_ftr[$];
  logic [TLV_W-1:0] exp_pt[$];
  dp_t              exp_dp[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int hdr_acc = 0;
  int dp_acc = 0;
  bit gap_en = 1'b0;

  function automatic logic [TLV_W-1:0] mk(input logic [7:0] typ, input logic sot,
                                          input logic eot, input logic [7:0] strb,
                                          input logic [63:0] d);
    return {typ, sot, eot, strb, d};
  endfunction

  function automatic logic [1:0] calc_bip(input logic [63:0] d);
    logic [1:0] b;
    b = 2'b00;
    for (int i = 0; i < 62; i++) begin
      if (i % 2 == 0) b[0] = b[0] ^ d[i];
      else            b[1] = b[1] ^ d[i];
    end
    return b;
  endfunction

  function automatic int nbytes(input logic [7:0] s);
    for (int k = 1; k <= 8; k++) begin
      if (s == 8'((1 << k) - 1)) return k;
    end
    return 0;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Show-ahead input FIFO: in_rd sampled mid-cycle, pop at the edge, new head #1 later.
  initial begin
    bit rd_s;
    bit gap;
    forever begin
      @(negedge clk);
      rd_s = in_rd;
      @(posedge clk);
      if (rd_s && fifo.size() > 0) void'(fifo.pop_front());
      #1;
      gap = gap_en ? 1'($urandom_range(0, 1)) : 1'b0;
      in_empty = (fifo.size() == 0) || gap;
      in_tlv   = (fifo.size() == 0) ? '0 : fifo[0];
    end
  end

  // Output monitors: each accepted word is checked against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frm_done) done_cnt++;
      if (hdr_valid && hdr_ready) begin
        hdr_acc++;
        checks++;
        if (exp_hdr.size() == 0) begin
          errors++;
          $display("FAIL hdr_unexpected got=%h", hdr_tlv);
        end else begin
          logic [TLV_W-1:0] e;
          e = exp_hdr.pop_front();
          if (hdr_tlv !== e) begin
            errors++;
            $display("FAIL hdr_word got=%h exp=%h", hdr_tlv, e);
          end
        end
      end
      if (dp_valid && dp_ready) begin
        dp_acc++;
        checks++;
        if (exp_dp.size() == 0) begin
          errors++;
          $display("FAIL dp_unexpected got=%h/%h/%b", dp_data, dp_bytes_valid, dp_data_type);
        end else begin
          dp_t e;
          e = exp_dp.pop_front();
          if ({dp_data, dp_bytes_valid, dp_data_type} !== e) begin
            errors++;
            $display("FAIL dp_beat got=%h/%h/%b exp=%h/%h/%b", dp_data, dp_bytes_valid,
                     dp_data_type, e.d, e.s, e.t);
          end
          checks++;
          if (frm_done !== (e.t == 2'b10)) begin
            errors++;
            $display("FAIL frm_done_with_beat got=%b exp=%b", frm_done, (e.t == 2'b10));
          end
        end
      end
      if (ftr_wr) begin
        checks++;
        if (exp_ftr.size() == 0) begin
          errors++;
          $display("FAIL ftr_unexpected got=%h", ftr_tlv);
        end else begin
          logic [TLV_W-1:0] e;
          e = exp_ftr.pop_front();
          if (ftr_tlv !== e) begin
            errors++;
            $display("FAIL ftr_word got=%h exp=%h", ftr_tlv, e);
          end
        end
      end
      if (pt_wr) begin
        checks++;
        if (exp_pt.size() == 0) begin
          errors++;
          $display("FAIL pt_unexpected got=%h", pt_tlv);
        end else begin
          logic [TLV_W-1:0] e;
          e = exp_pt.pop_front();
          if (pt_tlv !== e) begin
            errors++;
            $display("FAIL pt_word got=%h exp=%h", pt_tlv, e);
          end
        end
      end
    end
  end

  // Header plus data beats; without eot a forced empty last beat is expected.
  task automatic push_frame(input logic [7:0] typ, input int nfull, input logic [7:0] lstrb,
                            input bit eot, input bit bad_bip, output int bytes);
    logic [63:0] d;
    logic [TLV_W-1:0] w;
    d = rnd64();
    d[63:62] = calc_bip(d);
    if (bad_bip) d[63:62] = ~d[63:62];
    w = mk(typ, 1'b1, 1'b0, 8'hff, d);
    fifo.push_back(w);
    exp_hdr.push_back(w);
    bytes = 0;
    for (int i = 0; i < nfull; i++) begin
      d = rnd64();
      fifo.push_back(mk(typ, 1'b0, 1'b0, 8'hff, d));
      exp_dp.push_back('{d: d, s: 8'hff, t: 2'b00});
      bytes += 8;
    end
    if (eot) begin
      d = rnd64();
      fifo.push_back(mk(typ, 1'b0, 1'b1, lstrb, d));
      exp_dp.push_back('{d: d, s: lstrb, t: 2'b10});
      bytes += nbytes(lstrb);
    end else begin
      exp_dp.push_back('{d: 64'd0, s: 8'h00, t: 2'b10});
    end
  endtask

  task automatic push_footer(input int bytes, input int olim, input bit cceip,
                             input bit bip_err);
    logic [63:0] d;
    logic [TLV_W-1:0] w, e;
    for (int i = 0; i < 14; i++) begin
      d = rnd64();
      if (i == 13) d[15:0] = 16'h0000;
      w = mk(TypeFtr, i == 0, i == 13, 8'hff, d);
      fifo.push_back(w);
      e = w;
      if (i == 12 && !cceip) e[23:0] = 24'(bytes);
      if (i == 13) begin
        if (bip_err)           e[15:0] = ErrCode + 16'd1;
        else if (bytes > olim) e[15:0] = ErrCode;
      end
      exp_ftr.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_hdr.size() != 0 || exp_dp.size() != 0 ||
            exp_ftr.size() != 0 || exp_pt.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout pending in=%0d hdr=%0d dp=%0d ftr=%0d pt=%0d exp=0",
               fifo.size(), exp_hdr.size(), exp_dp.size(), exp_ftr.size(), exp_pt.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL rst_hdr_valid got=%b exp=0", hdr_valid); end
    checks++; if (dp_valid !== 1'b0) begin errors++; $display("FAIL rst_dp_valid got=%b exp=0", dp_valid); end
    checks++; if (ftr_wr !== 1'b0) begin errors++; $display("FAIL rst_ftr_wr got=%b exp=0", ftr_wr); end
    checks++; if (pt_wr !== 1'b0) begin errors++; $display("FAIL rst_pt_wr got=%b exp=0", pt_wr); end
    checks++; if (frm_bcnt !== '0) begin errors++; $display("FAIL rst_frm_bcnt got=%0d exp=0", frm_bcnt); end
    checks++; if (frm_done !== 1'b0) begin errors++; $display("FAIL rst_frm_done got=%b exp=0", frm_done); end
    checks++; if (hdr_tlv !== '0 || dp_data !== '0 || dp_data_type !== '0) begin
      errors++; $display("FAIL rst_data got=%h/%h/%b exp=0", hdr_tlv, dp_data, dp_data_type);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_rd !== 1'b0) begin errors++; $display("FAIL rst_in_rd_empty got=%b exp=0", in_rd); end
  endtask

  task automatic test_basic_frame();
    int bytes, d0;
    sw_OLIMIT = 24'd100;
    cceip_cfg = 1'b0;
    d0 = done_cnt;
    push_frame(TypeData, 3, 8'h0f, 1'b1, 1'b0, bytes);
    push_footer(bytes, 100, 1'b0, 1'b0);
    drain();
    checks++; if (frm_bcnt !== 24'd28) begin errors++; $display("FAIL basic_bcnt got=%0d exp=28", frm_bcnt); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_olimit();
    int bytes, d0;
    sw_OLIMIT = 24'd20;
    d0 = done_cnt;
    push_frame(TypeLz77, 3, 8'h0f, 1'b1, 1'b0, bytes);
    push_footer(bytes, 20, 1'b0, 1'b0);
    drain();
    checks++; if (frm_bcnt !== 24'd28) begin errors++; $display("FAIL olimit_bcnt got=%0d exp=28", frm_bcnt); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL olimit_done got=%0d exp=1", done_cnt - d0); end
    sw_OLIMIT = 24'd100;
  endtask

  task automatic test_empty_frame();
    logic [63:0] d;
    logic [TLV_W-1:0] w;
    int d0, h0;
    d0 = done_cnt;
    h0 = hdr_acc;
    d = rnd64();
    d[63:62] = calc_bip(d);
    w = mk(TypeDataUnk, 1'b1, 1'b1, 8'hff, d);
    fifo.push_back(w);
    exp_hdr.push_back(w);
    exp_dp.push_back('{d: 64'd0, s: 8'h00, t: 2'b11});
    drain();
    checks++; if (frm_bcnt !== 24'd0) begin errors++; $display("FAIL empty_bcnt got=%0d exp=0", frm_bcnt); end
    checks++; if (hdr_acc - h0 != 1) begin errors++; $display("FAIL empty_hdr_cnt got=%0d exp=1", hdr_acc - h0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL empty_done got=%0d exp=0", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int bytes, d0, n;
    d0 = done_cnt;
    gap_en = 1'b1;
    push_frame(TypeData, 7, 8'hff, 1'b1, 1'b0, bytes);
    push_footer(bytes, 100, 1'b0, 1'b0);
    n = 0;
    while (!dp_valid && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL bp_first_beat_timeout got=0 exp=1"); end
    @(posedge clk);
    #1 dp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dp_valid) begin
        checks++;
        if (in_rd !== 1'b0) begin errors++; $display("FAIL bp_in_rd_when_full got=%b exp=0", in_rd); end
      end
    end
    @(posedge clk);
    #1 dp_ready = 1'b1;
    drain();
    gap_en = 1'b0;
    checks++; if (frm_bcnt !== 24'd64) begin errors++; $display("FAIL bp_bcnt got=%0d exp=64", frm_bcnt); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_passthrough();
    logic [TLV_W-1:0] w;
    logic [7:0] typs[6];
    logic [1:0] se[6];
    int h0, p0, n;
    typs = '{8'h01, 8'h02, TypeData, TypeFtr, 8'h10, 8'h03};
    se   = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00};
    h0 = hdr_acc;
    p0 = dp_acc;
    for (int i = 0; i < 6; i++) begin
      w = mk(typs[i], se[i][1], se[i][0], 8'hff, rnd64());
      fifo.push_back(w);
      exp_pt.push_back(w);
    end
    n = 0;
    while ((fifo.size() != 0 || exp_pt.size() != 0) && n < 500) begin
      @(posedge clk);
      #1 pt_afull = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pt_afull) begin
        checks++;
        if (in_rd !== 1'b0) begin errors++; $display("FAIL pt_in_rd_afull got=%b exp=0", in_rd); end
      end
      n++;
    end
    pt_afull = 1'b0;
    drain();
    checks++; if (hdr_acc != h0) begin errors++; $display("FAIL pt_hdr_activity got=%0d exp=0", hdr_acc - h0); end
    checks++; if (dp_acc != p0) begin errors++; $display("FAIL pt_dp_activity got=%0d exp=0", dp_acc - p0); end
  endtask

  task automatic test_missing_eot();
    int b1, b2, d0;
    d0 = done_cnt;
    cceip_cfg = 1'b1;
    push_frame(TypeData, 2, 8'h00, 1'b0, 1'b0, b1);
    push_frame(TypeData, 1, 8'h03, 1'b1, 1'b1, b2);
    push_footer(b2, 100, 1'b1, BipEn);
    drain();
    checks++; if (frm_bcnt !== 24'd10) begin errors++; $display("FAIL miss_bcnt got=%0d exp=10", frm_bcnt); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL miss_done got=%0d exp=2", done_cnt - d0); end
    cceip_cfg = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_olimit();
    test_empty_frame();
    test_backpressure();
    test_passthrough();
    test_missing_eot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cr_xp10_decomp_fe_tlv_split.md
Name: cr_xp10_decomp_fe_tlv_split

Overview:
Front-end splitter. Reads one TLV stream and separates it into four outputs: the user-header word, the LZ data beats, the footer words and pass-through TLVs.
- It is the inverse of the back-end merge stage, which recombines header, LZ output and footer.
- Counts frame data bytes and checks them against the output limit.
- Patches footer words 12 and 13 with the byte count and any detected error, ready for later re-merge.

Parameters:
- OLIMIT_W, 24, width of the byte counter and of sw_OLIMIT.
- ERR_W, 16, width of the error_code field patched into footer word 13.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_empty  in  1  input FIFO empty; show-ahead FIFO, so in_tlv is valid whenever in_empty=0
- in_tlv  in  $bits(tlvp_if_bus_t)  input TLV word
- in_rd  out  1  input FIFO pop
- hdr_valid  out  1  user-header word valid
- hdr_tlv  out  $bits(tlvp_if_bus_t)  user-header word (sot word of a DATA/DATA_UNK/LZ77 TLV)
- hdr_ready  in  1  header sink ready
- dp_valid  out  1  data beat valid
- dp_data  out  64  data beat payload
- dp_bytes_valid  out  8  tstrb of the beat
- dp_data_type  out  2  00=mid, 10=last data beat, 11=empty-frame end
- dp_ready  in  1  data sink ready
- ftr_wr  out  1  footer word write
- ftr_tlv  out  $bits(tlvp_if_bus_t)  footer word after patching
- ftr_afull  in  1  footer FIFO almost full
- pt_wr  out  1  pass-through write
- pt_tlv  out  $bits(tlvp_if_bus_t)  pass-through word
- pt_afull  in  1  pass-through FIFO almost full
- sw_OLIMIT  in  OLIMIT_W  output byte limit
- sw_OLIMIT_ERR_CODE  in  ERR_W  error code reported on olimit
- cceip_cfg  in  1  when 1, footer word 12 is not patched
- frm_bcnt  out  OLIMIT_W  byte count of the current/last frame
- frm_done  out  1  one-cycle pulse when a frame's last data beat is emitted

Behaviour:
- Reset values: all valid/wr outputs 0, all data outputs 0, frm_bcnt 0, frm_done 0, state IDLE, ftr_cnt 0, olimit_err 0.
- Outputs are registered. Each output stage is a 1-entry skid buffer per port.
- Latency is 1 cycle from in_rd to the corresponding output valid/wr.
- in_rd = !in_empty && the target stage can accept the word:
  - target stage for each word class: hdr stage free or hdr_ready; dp stage free or dp_ready; !ftr_afull; !pt_afull.
  - At most one pop per cycle.
- FSM states IDLE, DATA, FTR.
- IDLE, classified by in_tlv.typen:
  - DATA, DATA_UNK or LZ77 with sot: word goes to the hdr port; frm_bcnt cleared to 0 and olimit_err cleared the same cycle.
    - If eot is also set (empty frame): a dp beat with data_type=11, bytes_valid=0, data=0 is emitted the following cycle; state stays IDLE.
    - Otherwise go to DATA.
  - FTR with sot: go to FTR; ftr_cnt=0.
  - Any other typen: word goes to pt; state stays IDLE.
- DATA:
  - Each pop emits one dp beat: dp_data=tdata, dp_bytes_valid=tstrb.
  - data_type=10 if eot, else 00. On eot: frm_done pulses in the same cycle as that dp_valid; go to IDLE.
  - frm_bcnt adds 1..8 for contiguous tstrb 01,03,07,0f,1f,3f,7f,ff. Any other tstrb adds 0.
  - frm_bcnt saturates at all-ones; no wrap.
  - olimit_err sets when updated frm_bcnt > sw_OLIMIT.
- FTR:
  - Each word goes to ftr; ftr_cnt increments per word.
  - Word 12, when !cceip_cfg: bytes_out field = frm_bcnt.
  - Word 13: if error_code==NO_ERRORS and olimit_err, then error_code=sw_OLIMIT_ERR_CODE.
  - On eot: ftr_cnt=0; go to IDLE.
  - ftr_cnt saturates at 63.
- Simultaneous events:
  - sot arriving while in DATA (missing eot): a dp beat with data_type=10, bytes_valid=0 is forced to close the frame. The word is not popped; it is reprocessed in IDLE.
  - Backpressure on dp during eot: frm_done is delayed until dp_valid is accepted.
- Reset mid-frame discards all partial state; no output asserts until the first sot after reset.

Optional Feature:
- Macro CR_XP10_FE_BIP2_CHK_EN.
- Defined: the header word's tdata[63:62] is checked against the bip2 computed over tdata with [63:62] zeroed.
  - On mismatch, a sticky bip_err is set for the frame.
  - Word-13 error_code is forced to sw_OLIMIT_ERR_CODE+1 if it would otherwise be NO_ERRORS. bip_err takes priority over olimit_err.
- Undefined: no check; no bip logic is present.

Test Plan:
- Header, 3 full beats, last beat tstrb=0x0f with eot, footer of 14 words, sw_OLIMIT=100, cceip_cfg=0 → hdr 1 word; dp types 00,00,00,10; frm_bcnt=28; frm_done 1 pulse; word12.bytes_out=28; word13 unchanged.
- Same frame with sw_OLIMIT=20 → word13.error_code=sw_OLIMIT_ERR_CODE; other words unchanged.
- Empty frame (sot&eot) → hdr 1 word; one dp beat type 11 with bytes_valid 0; frm_bcnt=0.
- dp_ready held low for 10 cycles mid-frame with random in_empty → no beat lost or duplicated; in_rd low while the skid buffer is full.
- Non-FTR, non-DATA TLV interleaved between frames; pt_afull toggled → all words appear on pt in order; no dp/hdr activity.
- Missing eot followed by a new sot → forced dp beat type 10, then the new frame is header-processed correctly. With CR_XP10_FE_BIP2_CHK_EN and a corrupted bip → word13 error_code = sw_OLIMIT_ERR_CODE+1.
